serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; computes diff = a - b one bit per clock, LSB first.
- Each step uses a single full-subtractor cell (the borrow counterpart of the lab full adder) plus a borrow flip-flop.
- Operands load on a start pulse; result is held until the next operation.
- Sits alongside the lab adder blocks as the arithmetic inverse, driven from board switches/keys or from a test controller.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
resetn  input  1  synchronous, active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  registered result a - b mod 2^WIDTH
bout  output  1  final borrow out (1 = unsigned a < b)

Behaviour:
- Reset: one clock and reset; reset is synchronous, active-low (resetn sampled on rising clk). While resetn=0 at an edge: state=IDLE, busy=0, done=0, diff=0, bout=0, shift regs/borrow/counter cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0. If start=1 at an edge:
  - load sa<=a, sb<=b, br<=0, cnt<=0, partial result reg<=0;
  - go to SHIFT.
- SHIFT: busy=1. Each edge:
  - d = sa[0] ^ sb[0] ^ br;
  - br <= (~sa[0] & sb[0]) | (~(sa[0]^sb[0]) & br);
  - d shifted into partial result MSB, partial shifted right;
  - sa, sb shifted right; cnt <= cnt+1.
  - On the edge where cnt == WIDTH-1: copy completed partial (including this step's d) into diff, final borrow into bout; go to DONE.
- DONE: done=1, busy=0 for exactly one cycle; next edge returns to IDLE unconditionally.
- Timing: start accepted at edge 0 -> done high during the cycle after edge WIDTH. A new start is first accepted in IDLE at edge WIDTH+2. Back-to-back throughput is one result per WIDTH+2 cycles.
- start is ignored in SHIFT and DONE; a start held high re-triggers on the first IDLE edge.
- a and b may change freely after capture.
- diff and bout change only on entry to DONE (and at reset); otherwise held stable, including during a subsequent operation.
- Arithmetic: diff = (a - b) mod 2^WIDTH; bout = 1 iff a < b unsigned. The counter is sized to hold WIDTH-1.

Optional Feature:
- SUB_SIGNED_OVF_EN defined:
  - adds output port ovf, 1 bit, reset 0;
  - updated only on entry to DONE with (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated on captured operands;
  - signals two's-complement overflow.
- Not defined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, start pulse -> busy high 8 cycles, done pulse cycle 9, diff=0x23, bout=0.
- a=0x12, b=0x35 -> diff=0xDD, bout=1; a=0x00, b=0x01 -> diff=0xFF, bout=1; a=b=0xA5 -> diff=0x00, bout=0.
- start held high continuously, a=0x10, b=0x01 -> exactly one result per 10 cycles, diff=0x0F each time. Operands changed mid-SHIFT do not affect the result.
- resetn=0 on the 4th SHIFT cycle -> next cycle busy=0, done=0, diff=0, bout=0, no done pulse. A fresh start afterwards gives a correct result.
- SUB_SIGNED_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1; a=0x05, b=0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one full-subtractor step per clock, LSB first.
// Optional SUB_SIGNED_OVF_EN adds a registered two's-complement overflow flag (ovf).
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] part;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bnext;

`ifdef SUB_SIGNED_OVF_EN
  // sa/sb are consumed by shifting, so the operand sign bits are kept aside
  logic             amsb;
  logic             bmsb;
`endif

  always_comb begin
    d     = sa[0] ^ sb[0] ^ br;
    bnext = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      part  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
`ifdef SUB_SIGNED_OVF_EN
      ovf   <= 1'b0;
      amsb  <= 1'b0;
      bmsb  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            part  <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SUB_SIGNED_OVF_EN
            amsb  <= a[WIDTH-1];
            bmsb  <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          part <= {d, part[WIDTH-1:1]};
          sa   <= {1'b0, sa[WIDTH-1:1]};
          sb   <= {1'b0, sb[WIDTH-1:1]};
          br   <= bnext;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= {d, part[WIDTH-1:1]};
            bout  <= bnext;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SUB_SIGNED_OVF_EN
            ovf   <= (amsb != bmsb) && (d != amsb);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors push expectations, a monitor checks on done.
// Define SUB_SIGNED_OVF_EN for both RTL and bench to cover the ovf output.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_SIGNED_OVF_EN
  logic             ovf;
`endif

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .resetn(resetn),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
    int unsigned      cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  bit          rs = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rs  <= resetn;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops on each done pulse; between pulses the result must hold.
  initial begin
    exp_t             e;
    logic [WIDTH-1:0] held_d = '0;
    logic             held_b = 1'b0;
    logic             held_o = 1'b0;
    int unsigned      run = 0;
    forever begin
      @(negedge clk);
      if (!rs) begin
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_SIGNED_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        q.delete();
        held_d = '0;
        held_b = 1'b0;
        held_o = 1'b0;
        run    = 0;
      end else begin
        if (busy) run++;
        if (done) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 want no pending op (cycle %0d)", cyc);
          end else begin
            e = q.pop_front();
            chk("diff", 32'(diff), 32'(e.d));
            chk("bout", 32'(bout), 32'(e.bo));
            chk("done_cycle", cyc, e.cyc);
            chk("busy_len", run, WIDTH);
            chk("busy_in_done", 32'(busy), 32'd0);
`ifdef SUB_SIGNED_OVF_EN
            chk("ovf", 32'(ovf), 32'(e.ov));
`endif
            held_d = e.d;
            held_b = e.bo;
            held_o = e.ov;
          end
          run = 0;
        end else begin
          chk("hold_diff", 32'(diff), 32'(held_d));
          chk("hold_bout", 32'(bout), 32'(held_b));
`ifdef SUB_SIGNED_OVF_EN
          chk("hold_ovf", 32'(ovf), 32'(held_o));
`endif
        end
      end
    end
  end

  task automatic push(input logic [WIDTH-1:0] ed, input logic eb, input logic eo,
                      input int unsigned c0);
    exp_t e;
    e.d   = ed;
    e.bo  = eb;
    e.ov  = eo;
    e.cyc = c0 + 1 + WIDTH;
    q.push_back(e);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 4 * (WIDTH + 2)) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  // One operation; operands are scrambled right after capture.
  task automatic op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                    input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    a     = va;
    b     = vb;
    start = 1'b1;
    push(ed, eb, eo, cyc);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    drain();
  endtask

  initial begin
    int unsigned c0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);

    op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
    op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    op(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);
    op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);

    // start held high: accepted every WIDTH+2 cycles
    @(negedge clk);
    a     = 8'h10;
    b     = 8'h01;
    start = 1'b1;
    c0    = cyc;
    for (int unsigned k = 0; k < 3; k++) push(8'h0F, 1'b0, 1'b0, c0 + k * (WIDTH + 2));
    repeat (2 * (WIDTH + 2) + 1) @(posedge clk);
    #1 start = 1'b0;
    drain();

    // reset in the 4th SHIFT cycle aborts with no done pulse
    @(negedge clk);
    a     = 8'h35;
    b     = 8'h12;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2 * WIDTH) @(posedge clk);

    op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    chk("leftover", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit want finish");
    $fatal(1, "watchdog");
  end

endmodule
